// File: rtl/gat_sched_pkg.sv
`default_nettype none
// ============================================================================
// gat_sched_pkg: shared types and constants for the GAT layer scheduler
// Revision: 1.0
// ============================================================================
package gat_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOAD = 3'd1,
    S_KICK      = 3'd2,
    S_WAIT_CORE = 3'd3,
    S_DRAIN     = 3'd4,
    S_NEXT      = 3'd5
  } sched_state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

  typedef logic [1:0] layer_idx_t;

endpackage
`default_nettype wire

// File: rtl/gat_feat_reader.sv
`default_nettype none
// ============================================================================
// gat_feat_reader: feature BRAM address generator, latency pipe and credit FIFO
// Revision: 1.0
// ============================================================================
module gat_feat_reader
  import gat_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 43328,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_flush,
  input  logic                  i_en,
  output logic [ADDR_W-1:0]     o_addr,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_done
);

  localparam logic [CNT_W:0] c_fifo_lim = (CNT_W+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]     r_addr;
  logic                  r_all_issued;
  logic                  r_epoch;
  logic [RD_LATENCY-1:0] r_pv;
  logic [RD_LATENCY-1:0] r_pe;
  logic [RD_LATENCY-1:0] r_pl;
  logic [DATA_WIDTH-1:0] r_fd [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fl;
  logic [1:0]            r_wp;
  logic [1:0]            r_rp;
  logic [CNT_W-1:0]      r_cnt;

  logic [CNT_W-1:0] w_inflight;
  logic [CNT_W:0]   w_used;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_last_addr;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_pv[i]);
    end
  end

  // A slot freed by this cycle's pop may be re-credited immediately
  assign w_used      = {1'b0, r_cnt} + {1'b0, w_inflight};
  assign w_last_addr = (r_addr == ADDR_W'(DEPTH - 1));
  assign w_issue     = i_en & ~r_all_issued & (w_used < c_fifo_lim + {{CNT_W{1'b0}}, w_pop});
  assign w_push      = r_pv[RD_LATENCY-1] & (r_pe[RD_LATENCY-1] == r_epoch);
  assign o_valid     = (r_cnt != '0);
  assign w_pop       = o_valid & i_ready;
  assign o_data      = r_fd[r_rp];
  assign o_last      = o_valid & r_fl[r_rp];
  assign o_done      = w_pop & r_fl[r_rp];
  assign o_addr      = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_all_issued <= 1'b0;
      r_epoch      <= 1'b0;
      r_pv         <= '0;
      r_pe         <= '0;
      r_pl         <= '0;
      r_fl         <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fd[i] <= '0;
      end
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pl[i] <= r_pl[i-1];
      end
      r_pv[0] <= w_issue;
      r_pe[0] <= r_epoch;
      r_pl[0] <= w_last_addr;
      // Flipping the epoch orphans reads still in the pipe; they are dropped on return
      if (i_flush) begin
        r_epoch      <= ~r_epoch;
        r_addr       <= '0;
        r_all_issued <= 1'b0;
        r_wp         <= '0;
        r_rp         <= '0;
        r_cnt        <= '0;
      end else begin
        if (i_clear) begin
          r_addr       <= '0;
          r_all_issued <= 1'b0;
        end else if (w_issue) begin
          if (w_last_addr) r_all_issued <= 1'b1;
          else             r_addr       <= r_addr + 1'b1;
        end
        if (w_push) begin
          r_fd[r_wp] <= i_dout;
          r_fl[r_wp] <= r_pl[RD_LATENCY-1];
          r_wp       <= r_wp + 1'b1;
        end
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gat_layer_scheduler.sv
`default_nettype none
// ============================================================================
// gat_layer_scheduler: multi-layer GAT run sequencer; define GAT_SCHED_PERF_EN
// to enable the WAIT_CORE cycle counter on perf_cycles.   Revision: 1.0
// ============================================================================
module gat_layer_scheduler
  import gat_sched_pkg::*;
#(
  parameter int NUM_LAYERS        = 2,
  parameter int DATA_WIDTH        = 8,
  parameter int NEW_FEATURE_DEPTH = 43328,
  parameter int FEAT_ADDR_W       = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY        = 2,
  parameter int TIMEOUT_CYCLES    = 2**24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output layer_idx_t             layer_idx,
  output logic                   load_req,
  input  logic                   h_data_bram_load_done,
  input  logic                   h_node_info_bram_load_done,
  input  logic                   wgt_bram_load_done,
  output logic                   gat_layer,
  output logic                   gat_start,
  input  logic                   gat_ready,
  output logic [FEAT_ADDR_W-1:0] feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0]  feat_bram_dout,
  output logic [DATA_WIDTH-1:0]  m_feat_data,
  output logic                   m_feat_valid,
  output logic                   m_feat_last,
  input  logic                   m_feat_ready,
  output logic [31:0]            perf_cycles
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  sched_state_e     r_state;
  logic             r_ready_q;
  logic [TMO_W-1:0] r_tmo;
  logic             w_edge;
  logic             w_drain_done;
  logic             w_loads_ok;

  assign w_edge     = gat_ready & ~r_ready_q;
  assign w_loads_ok = h_data_bram_load_done & h_node_info_bram_load_done & wgt_bram_load_done;
  assign gat_layer  = layer_idx[0];

  gat_feat_reader #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NEW_FEATURE_DEPTH),
    .ADDR_W     (FEAT_ADDR_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_reader (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == S_KICK),
    .i_flush (abort),
    .i_en    (r_state == S_DRAIN),
    .o_addr  (feat_bram_addrb),
    .i_dout  (feat_bram_dout),
    .o_data  (m_feat_data),
    .o_valid (m_feat_valid),
    .o_last  (m_feat_last),
    .i_ready (m_feat_ready),
    .o_done  (w_drain_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ready_q <= 1'b0;
      r_tmo     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      layer_idx <= '0;
      load_req  <= 1'b0;
      gat_start <= 1'b0;
    end else begin
      r_ready_q <= gat_ready;
      done      <= 1'b0;
      gat_start <= 1'b0;
      // abort outranks everything, including a coincident start in IDLE
      if (abort) begin
        r_state   <= S_IDLE;
        busy      <= 1'b0;
        layer_idx <= '0;
        load_req  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state   <= S_WAIT_LOAD;
              busy      <= 1'b1;
              error     <= 1'b0;
              layer_idx <= '0;
              load_req  <= 1'b1;
            end
          end
          S_WAIT_LOAD: begin
            if (w_loads_ok) begin
              load_req  <= 1'b0;
              gat_start <= 1'b1;
              r_state   <= S_KICK;
            end
          end
          S_KICK: begin
            r_tmo   <= '0;
            r_state <= S_WAIT_CORE;
          end
          S_WAIT_CORE: begin
            if (w_edge) begin
              r_state <= S_DRAIN;
            end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              error   <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          S_DRAIN: begin
            if (w_drain_done) r_state <= S_NEXT;
          end
          S_NEXT: begin
            if (layer_idx == layer_idx_t'(NUM_LAYERS - 1)) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              layer_idx <= layer_idx + 1'b1;
              load_req  <= 1'b1;
              r_state   <= S_WAIT_LOAD;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef GAT_SCHED_PERF_EN
  logic [31:0] r_perf_cnt;

  // Latched value counts the edge cycle itself, i.e. all WAIT_CORE cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cnt  <= '0;
      perf_cycles <= '0;
    end else if (abort) begin
      r_perf_cnt  <= '0;
      perf_cycles <= '0;
    end else if (r_state == S_KICK) begin
      r_perf_cnt <= '0;
    end else if (r_state == S_WAIT_CORE) begin
      if (w_edge) perf_cycles <= (r_perf_cnt == '1) ? r_perf_cnt : r_perf_cnt + 1'b1;
      if (r_perf_cnt != '1) r_perf_cnt <= r_perf_cnt + 1'b1;
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gat_layer_scheduler.sv
`default_nettype none
// ============================================================================
// tb_gat_layer_scheduler: randomized scoreboard bench for gat_layer_scheduler
// Revision: 1.0
// ============================================================================
module tb_gat_layer_scheduler;

  localparam int NL    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int RDL   = 3;
  localparam int TMO   = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic          busy, done, error;
  logic [1:0]    layer_idx;
  logic          load_req;
  logic          h_ld, n_ld, w_ld;
  logic          gat_layer, gat_start, gat_ready;
  logic [AW-1:0] feat_bram_addrb;
  logic [DW-1:0] feat_bram_dout;
  logic [DW-1:0] m_feat_data;
  logic          m_feat_valid, m_feat_last, m_feat_ready;
  logic [31:0]   perf_cycles;

  int          checks = 0;
  int          errors = 0;
  int          xfers = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  bit          bp_mode = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic [8:0]  exp_q [$];
  logic [8:0]  mon_e;
  bit          hold_chk = 1'b0;
  logic [7:0]  held = 8'h00;

  gat_layer_scheduler #(
    .NUM_LAYERS        (NL),
    .DATA_WIDTH        (DW),
    .NEW_FEATURE_DEPTH (DEPTH),
    .FEAT_ADDR_W       (AW),
    .RD_LATENCY        (RDL),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .abort                      (abort),
    .busy                       (busy),
    .done                       (done),
    .error                      (error),
    .layer_idx                  (layer_idx),
    .load_req                   (load_req),
    .h_data_bram_load_done      (h_ld),
    .h_node_info_bram_load_done (n_ld),
    .wgt_bram_load_done         (w_ld),
    .gat_layer                  (gat_layer),
    .gat_start                  (gat_start),
    .gat_ready                  (gat_ready),
    .feat_bram_addrb            (feat_bram_addrb),
    .feat_bram_dout             (feat_bram_dout),
    .m_feat_data                (m_feat_data),
    .m_feat_valid               (m_feat_valid),
    .m_feat_last                (m_feat_last),
    .m_feat_ready               (m_feat_ready),
    .perf_cycles                (perf_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_f(input int a, input logic [7:0] s);
    logic [31:0] t;
    t = a * 29 + a / 16;
    return t[7:0] ^ s;
  endfunction

  // Feature BRAM: data for the address presented in cycle t appears in cycle t+RDL
  logic [AW-1:0] a_pipe [RDL];
  always @(posedge clk) begin
    a_pipe[0] <= feat_bram_addrb;
    for (int i = 1; i < RDL; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign feat_bram_dout = mem_f(int'(a_pipe[RDL-1]), seed);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 load_req, 1 gat_start, 2 queue drained, 3 error, 4 done count, 5 transfer count
  task automatic wait_for(input int which, input int budget, input string name, input int tgt);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      case (which)
        0: ok = load_req;
        1: ok = gat_start;
        2: ok = (exp_q.size() == 0);
        3: ok = error;
        4: ok = (done_cnt >= tgt);
        default: ok = (xfers >= tgt);
      endcase
    end
    chk({"wait ", name}, 32'(ok), 32'd1);
  endtask

  task automatic push_layer();
    seed = 8'($urandom);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({a == DEPTH - 1, mem_f(a, seed)});
  endtask

  task automatic load_and_kick(input int l);
    wait_for(0, 300, "load_req", 0);
    chk("layer_idx", 32'(layer_idx), 32'(l));
    repeat (10) step();
    h_ld = 1'b1; n_ld = 1'b1; w_ld = 1'b1;
    wait_for(1, 20, "gat_start", 0);
    h_ld = 1'b0; n_ld = 1'b0; w_ld = 1'b0;
    chk("gat_layer", 32'(gat_layer), 32'(l % 2));
  endtask

  task automatic do_layer(input int l, input int dly, input bit keep_high, input bit stale);
    int x0;
    load_and_kick(l);
    x0 = xfers;
    if (stale) begin
      repeat (30) step();
      chk("stale ready: no words", 32'(xfers - x0), 32'd0);
      chk("stale ready: valid low", 32'(m_feat_valid), 32'd0);
      chk("stale ready: no reads", 32'(feat_bram_addrb), 32'd0);
      gat_ready = 1'b0;
      step();
    end else begin
      repeat (dly) step();
    end
    push_layer();
    gat_ready = 1'b1;
    wait_for(2, 4000, "layer drained", 0);
    chk("layer word count", 32'(xfers - x0), 32'(DEPTH));
    if (!stale) begin
`ifdef GAT_SCHED_PERF_EN
      chk_rng("perf_cycles", int'(perf_cycles), dly - 1, dly + 1);
`else
      chk("perf_cycles", perf_cycles, 32'd0);
`endif
    end
    if (!keep_high) gat_ready = 1'b0;
  endtask

  task automatic do_run(input int dly, input bit stale);
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy after start", 32'(busy), 32'd1);
    chk("error cleared by start", 32'(error), 32'd0);
    for (int l = 0; l < NL; l++) do_layer(l, dly, stale && l == 0, stale && l == 1);
    wait_for(4, 20, "done", d0 + 1);
    repeat (3) step();
    chk("one done pulse", 32'(done_cnt - d0), 32'd1);
    chk("busy after done", 32'(busy), 32'd0);
  endtask

  initial begin
    m_feat_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_feat_ready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hold_chk) chk("backpressure hold", {23'd0, m_feat_valid, m_feat_data}, {23'd0, 1'b1, held});
        if (done) done_cnt++;
        if (m_feat_valid && m_feat_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected word: got %0h, expected no word", m_feat_data);
          end else begin
            mon_e = exp_q.pop_front();
            chk("stream word {last,data}", {23'd0, m_feat_last, m_feat_data}, {23'd0, mon_e});
            xfers++;
          end
        end
        hold_chk = m_feat_valid && !m_feat_ready;
        held = m_feat_data;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  x, k, d0;
    bit  saw_valid;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    h_ld = 1'b0; n_ld = 1'b0; w_ld = 1'b0; gat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset control outputs",
        {22'd0, busy, done, error, layer_idx, load_req, gat_start, m_feat_valid, m_feat_last, gat_layer}, 32'd0);
    chk("reset addr", 32'(feat_bram_addrb), 32'd0);
    chk("reset data", 32'(m_feat_data), 32'd0);
    chk("reset perf", perf_cycles, 32'd0);
    rst = 1'b0;
    repeat (2) step();

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    chk("abort beats start: busy", 32'(busy), 32'd0);
    chk("abort beats start: load_req", 32'(load_req), 32'd0);

    x = xfers;
    do_run(100, 1'b0);
    chk("full run word count", 32'(xfers - x), 32'(NL * DEPTH));

    bp_mode = 1'b1;
    do_run(250, 1'b0);
    bp_mode = 1'b0;

    gat_ready = 1'b0;
    do_run(100, 1'b1);

    // Timeout: core never answers
    start = 1'b1;
    step();
    start = 1'b0;
    load_and_kick(0);
    k = cyc;
    d0 = done_cnt;
    wait_for(3, TMO + 200, "timeout error", 0);
    chk_rng("timeout latency", cyc - k, TMO, TMO + 2);
    chk("busy after timeout", 32'(busy), 32'd0);
    repeat (5) step();
    chk("no done on timeout", 32'(done_cnt - d0), 32'd0);
    chk("error sticky", 32'(error), 32'd1);
    do_run(100, 1'b0);

    // Abort mid-drain
    start = 1'b1;
    step();
    start = 1'b0;
    load_and_kick(0);
    repeat (5) step();
    push_layer();
    x = xfers;
    gat_ready = 1'b1;
    wait_for(5, 500, "20 words", x + 20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_q.delete();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort valid", 32'(m_feat_valid), 32'd0);
    chk("abort load_req", 32'(load_req), 32'd0);
    gat_ready = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_feat_valid) saw_valid = 1'b1;
    end
    chk("no late words after abort", 32'(saw_valid), 32'd0);
    do_run(100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
